// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving two masters serialised access to a single-port RAM.
// Each transaction runs grant/strobe (ACCESS), data return (RESP), then a one-cycle ack in IDLE.

module dmem_arb_port #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set,
  input  logic                  done,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  gnt,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt   <= 1'b0;
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      if (set)       gnt <= 1'b1;
      else if (done) gnt <= 1'b0;
      ack <= done;
      // read data is held until this master's next read completes
      if (load) rdata <= ram_rdata;
    end
  end
endmodule

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int NM = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic [NM-1:0]                 req, wr, gnt, ack, elig;
  logic [NM-1:0][ADDR_WIDTH-1:0] addr;
  logic [NM-1:0][DATA_WIDTH-1:0] wdata, rdata;
  logic [NM-1:0]                 gnt_set, done, load;

  logic                  win, win_valid;
  logic                  last_owner, last_owner_nxt;
  logic                  cap_wr, cap_wr_nxt;
  logic                  ram_ce_nxt, ram_we_nxt;
  logic [ADDR_WIDTH-1:0] ram_addr_nxt;
  logic [DATA_WIDTH-1:0] ram_wdata_nxt;

  assign req   = {m1_req, m0_req};
  assign wr    = {m1_wr, m0_wr};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];
  assign m0_ack   = ack[0];
  assign m1_ack   = ack[1];
  assign m0_rdata = rdata[0];
  assign m1_rdata = rdata[1];

  for (genvar i = 0; i < NM; i++) begin : g_port
    dmem_arb_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
      .clk       (clk),
      .rst       (rst),
      .set       (gnt_set[i]),
      .done      (done[i]),
      .load      (load[i]),
      .ram_rdata (ram_rdata),
      .gnt       (gnt[i]),
      .ack       (ack[i]),
      .rdata     (rdata[i])
    );
  end

  // A request seen alongside its own ack belongs to the finished transaction.
  always_comb begin
    elig      = req & ~ack;
    win_valid = |elig;
    win       = (&elig) ? ~last_owner : elig[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last_owner doubles as the current transaction owner from grant to ack.
  always_comb begin
    gnt_set        = '0;
    done           = '0;
    load           = '0;
    ram_ce_nxt     = ram_ce;
    ram_we_nxt     = ram_we;
    ram_addr_nxt   = ram_addr;
    ram_wdata_nxt  = ram_wdata;
    last_owner_nxt = last_owner;
    cap_wr_nxt     = cap_wr;
    case (state)
      IDLE: begin
        if (win_valid) begin
          gnt_set[win]   = 1'b1;
          last_owner_nxt = win;
          cap_wr_nxt     = wr[win];
          ram_ce_nxt     = 1'b1;
          ram_we_nxt     = wr[win];
          ram_addr_nxt   = addr[win];
          ram_wdata_nxt  = wdata[win];
        end
      end
      ACCESS: begin
        ram_ce_nxt = 1'b0;
        ram_we_nxt = 1'b0;
      end
      RESP: begin
        done[last_owner] = 1'b1;
        load[last_owner] = ~cap_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      last_owner <= 1'b1;
      cap_wr     <= 1'b0;
    end else begin
      ram_ce     <= ram_ce_nxt;
      ram_we     <= ram_we_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_wdata  <= ram_wdata_nxt;
      last_owner <= last_owner_nxt;
      cap_wr     <= cap_wr_nxt;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read RAM model.
// Unwritten RAM words read back as 32'hA5A5_0000 | address.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_wr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_gnt, m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_wr = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_gnt, m1_ack;
  logic [31:0] m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  int n_chk = 0, n_fail = 0;
  int ack0_cnt = 0, ack1_cnt = 0, viol = 0, ce_seen = 0;

  logic [31:0] mem [0:255];
  logic        written [0:255];

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      mem[ram_addr[9:2]]     <= ram_wdata;
      written[ram_addr[9:2]] <= 1'b1;
    end else if (ram_ce) begin
      ram_rdata <= written[ram_addr[9:2]] ? mem[ram_addr[9:2]] : (32'hA5A5_0000 | ram_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then sample away from it
  task automatic tick();
    @(posedge clk);
    #1;
    if (m0_ack) ack0_cnt++;
    if (m1_ack) ack1_cnt++;
    if (ram_ce) ce_seen++;
    if (m0_gnt && m1_gnt) viol++;
    if ((m0_gnt && m0_ack) || (m1_gnt && m1_ack)) viol++;
  endtask

  initial begin
    int g_cnt, a_cnt, rep, seq_err, last_g, a0, a1;
    logic p0, p1;
    for (int i = 0; i < 256; i++) begin
      written[i] = 1'b0;
      mem[i]     = '0;
    end

    // reset and idle
    tick(); tick();
    chk("rst_ram_ce", {31'd0, ram_ce}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_gnt_ack", {28'd0, m0_gnt, m0_ack, m1_gnt, m1_ack}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    rst = 1'b1;
    tick(); tick(); tick();
    chk("idle_no_ce", ce_seen, 32'd0);

    // m0 write 0x10 then read it back
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    tick();
    chk("wr_ce", {30'd0, ram_ce, ram_we}, 32'd3);
    chk("wr_addr", ram_addr, 32'h10);
    chk("wr_wdata", ram_wdata, 32'hDEADBEEF);
    chk("wr_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    m0_req = 1'b0; m0_wdata = 32'h0;
    tick();
    chk("wr_ce_drop", {30'd0, ram_ce, ram_we}, 32'd0);
    chk("wr_gnt_hold", {31'd0, m0_gnt}, 32'd1);
    tick();
    chk("wr_ack", {30'd0, m0_gnt, m0_ack}, 32'd1);
    chk("wr_mem", mem[4], 32'hDEADBEEF);
    tick();
    chk("wr_ack_clear", {31'd0, m0_ack}, 32'd0);
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h10;
    tick();
    chk("rd_ce", {30'd0, ram_ce, ram_we}, 32'd2);
    m0_req = 1'b0;
    tick();
    chk("rd_ce_drop", {31'd0, ram_ce}, 32'd0);
    tick();
    chk("rd_ack", {31'd0, m0_ack}, 32'd1);
    chk("rd_data", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_quiet", {31'd0, m1_ack}, 32'd0);
    chk("rd_m1_rdata", m1_rdata, 32'd0);
    tick();

    // simultaneous first requests after reset
    rst = 1'b0; tick(); rst = 1'b1; tick();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h20;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h24;
    tick();
    chk("tie_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    chk("tie_addr0", ram_addr, 32'h20);
    m0_req = 1'b0;
    tick(); tick();
    chk("tie_ack0", {31'd0, m0_ack}, 32'd1);
    chk("tie_rdata0", m0_rdata, 32'hA5A50020);
    chk("tie_m1_wait", {31'd0, m1_gnt}, 32'd0);
    tick();
    chk("tie_gnt1", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    chk("tie_addr1", ram_addr, 32'h24);
    m1_req = 1'b0;
    tick(); tick();
    chk("tie_ack1", {30'd0, m1_ack, m0_ack}, 32'd2);
    chk("tie_rdata1", m1_rdata, 32'hA5A50024);
    chk("tie_rdata0_hold", m0_rdata, 32'hA5A50020);
    tick();

    // sustained contention for 20 cycles
    m0_req = 1'b1; m0_addr = 32'h50; m1_req = 1'b1; m1_addr = 32'h54;
    g_cnt = 0; a_cnt = 0; rep = 0; seq_err = 0; last_g = -1;
    p0 = m0_gnt; p1 = m1_gnt;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m0_ack || m1_ack) a_cnt++;
      if ((m0_gnt && !p0) || (m1_gnt && !p1)) begin
        if (m1_gnt != (g_cnt % 2 == 1)) seq_err++;
        if (last_g == int'(m1_gnt)) rep++;
        last_g = int'(m1_gnt);
        g_cnt++;
      end
      p0 = m0_gnt; p1 = m1_gnt;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("rr_grants", g_cnt, 32'd7);
    chk("rr_acks", a_cnt, 32'd6);
    chk("rr_sequence", seq_err, 32'd0);
    chk("rr_no_repeat", rep, 32'd0);
    tick(); tick(); tick();

    // held request from m1: two reads
    a1 = ack1_cnt;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h30;
    tick();
    chk("held_gnt1", {31'd0, m1_gnt}, 32'd1);
    chk("held_addr1", ram_addr, 32'h30);
    tick(); tick();
    chk("held_ack1", {31'd0, m1_ack}, 32'd1);
    chk("held_rdata1", m1_rdata, 32'hA5A50030);
    m1_addr = 32'h34;
    tick();
    chk("held_no_dup", {30'd0, m1_gnt, ram_ce}, 32'd0);
    tick();
    chk("held_gnt2", {30'd0, m1_gnt, ram_ce}, 32'd3);
    chk("held_addr2", ram_addr, 32'h34);
    m1_req = 1'b0;
    tick(); tick();
    chk("held_ack2", {31'd0, m1_ack}, 32'd1);
    chk("held_rdata2", m1_rdata, 32'hA5A50034);
    tick(); tick();
    chk("held_ack_count", ack1_cnt - a1, 32'd2);

    // reset during ACCESS of an m1 write
    a1 = ack1_cnt; a0 = ack0_cnt;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h40; m1_wdata = 32'hCAFEF00D;
    tick();
    chk("abort_pre", {30'd0, m1_gnt, ram_ce}, 32'd3);
    m1_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_ce", {30'd0, ram_ce, ram_we}, 32'd0);
    chk("abort_gnt", {30'd0, m1_gnt, m1_ack}, 32'd0);
    chk("abort_addr", ram_addr, 32'd0);
    tick(); tick();
    rst = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h40;
    tick();
    chk("post_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    tick(); tick();
    chk("post_ack", {31'd0, m0_ack}, 32'd1);
    chk("post_rdata", m0_rdata, 32'hA5A50040);
    tick();
    chk("abort_no_ack", ack1_cnt - a1, 32'd0);
    chk("post_ack_count", ack0_cnt - a0, 32'd1);
    chk("gnt_exclusive", viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter that shares the single-port DataMem (RAM) between the CPU data path (master 0, fed from the memory/IO controller RAM side) and a secondary master (master 1: DMA / program-loader / debug port).
- Serialises requests and issues one RAM access per transaction.
- Returns read data and a one-cycle acknowledge to the winning master.
- Sits between the memory/IO controller and DataMem in the SOC top.

Parameters:
- ADDR_WIDTH, 32, width of master and RAM address buses (byte address passed through unmodified).
- DATA_WIDTH, 32, width of write/read data buses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0_req  in  1  master 0 request (level).
- m0_wr  in  1  master 0 direction: 1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_gnt  out  1  master 0 owns the RAM (ACCESS and RESP states).
- m0_ack  out  1  one-cycle transaction-done pulse for master 0.
- m0_rdata  out  DATA_WIDTH  master 0 read data, held.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata: same as the m0_* ports, for master 1.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable: 1 = write, 0 = read.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a ce=1, we=0 edge (synchronous read).

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE; all gnt/ack=0; ram_ce=0, ram_we=0, ram_addr=0, ram_wdata=0; m0_rdata=m1_rdata=0; last_owner=1, so master 0 wins the first tie.
- State IDLE: at each edge, evaluate eligible requests.
  - A request is eligible if mX_req=1 AND mX_ack=0 in that cycle; req seen in the same cycle as its own ack is ignored.
  - None eligible: stay in IDLE.
  - One eligible: that master wins.
  - Both eligible: the master != last_owner wins (round-robin).
  - On a win: capture winner's wr/addr/wdata; set last_owner=winner, gnt_winner=1, ram_ce=1, ram_we=wr, ram_addr=addr, ram_wdata=wdata; go to ACCESS.
- State ACCESS (1 cycle): RAM strobe visible; the RAM commits the write or launches the read at the closing edge. At that edge: ram_ce=0, ram_we=0, ram_addr/ram_wdata hold; go to RESP.
- State RESP (1 cycle): ram_rdata is valid.
  - At the closing edge, if the captured op is a read: mX_rdata <= ram_rdata. Writes leave mX_rdata unchanged.
  - Same edge: mX_ack=1, gnt cleared, go to IDLE.
- ack is high for exactly the first IDLE cycle after RESP, then clears.
- During that cycle the other master may be granted (its req is eligible); the acked master's req is masked.
- Latency: req high before edge E0 → ram_ce high in cycle E0–E1 → ack high in cycle E2–E3.
  - Read data is on mX_rdata in the same cycle as ack and holds until that master's next read completes.
- Throughput: one transaction per 3 cycles. With both masters holding req continuously, grants alternate 0,1,0,1…
- Request fields only need to be stable at the granting edge; later changes are ignored. Deasserting req after grant does not abort the transaction; ack is still issued.
- At most one gnt is high at any time. gnt and ack are never high together for the same master.
- Reset mid-transaction: immediate abort, all outputs to reset values. A write in ACCESS is not guaranteed committed. No ack is issued for the aborted transaction.
- Addresses/data are passed through with no width conversion or alignment check.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, reqs=0 → all outputs 0; stays IDLE, ram_ce never high.
- Single write then read by master 0: write addr 0x10, data 0xDEADBEEF, then read 0x10.
  - ram_ce/we pulses exactly one cycle each, ack 2 cycles after ram_ce.
  - m0_rdata=0xDEADBEEF with m0_ack; m1 outputs untouched.
- Simultaneous first requests: m0 reads 0x20, m1 reads 0x24 in the same cycle after reset.
  - m0 granted first; m1 granted in m0's ack cycle; acks 3 cycles apart.
  - Each rdata matches its own RAM model location.
- Sustained contention: both reqs held high for 20 cycles → grant sequence 0,1,0,1… with ~6 transactions and no master granted twice in a row.
- Held req: m1 holds req for two reads (0x30, then 0x34).
  - The ack cycle does not start a duplicate grant; the second grant follows the ack cycle.
  - Exactly 2 acks.
- Reset mid-op: assert rst=0 during ACCESS of an m1 write to 0x40.
  - Same cycle: ram_ce=0, gnt=0, no ack.
  - After release, an m0 read of 0x40 completes normally.
